tl_ul_a_source_gate: RTL
========================

Name: tl_ul_a_source_gate

Overview:
- TileLink-UL A-channel staging buffer that sits directly upstream of the link protocol monitor.
- Queues master A requests in a small FIFO and forwards them to the monitored link.
- Never issues an A beat whose source ID is still in flight: a source is released only when the matching D response fires.
- Guarantees the downstream monitor never sees source reuse or an unsolicited D response from this master's traffic.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- SOURCE_BITS, 2, width of A/D source field; 2^SOURCE_BITS in-flight tracking bits.
- ADDR_BITS, 32, A address width.
- DATA_BITS, 32, A data width; mask width is DATA_BITS/8.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_a_valid  input  1  upstream A request valid.
- in_a_ready  output  1  upstream A request accepted.
- in_a_opcode  input  3  TL opcode: 0 PutFull, 1 PutPartial, 4 Get.
- in_a_param  input  3  TL param.
- in_a_size  input  3  log2 of transfer bytes.
- in_a_source  input  SOURCE_BITS  source ID.
- in_a_address  input  ADDR_BITS  byte address.
- in_a_mask  input  DATA_BITS/8  byte lanes.
- in_a_data  input  DATA_BITS  write data.
- out_a_valid  output  1  A beat to link/monitor.
- out_a_ready  input  1  link accepts beat.
- out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data  output  same widths as in_a_*  head-entry fields.
- d_valid  input  1  D channel valid (observed only).
- d_ready  input  1  D channel ready (observed only).
- d_opcode  input  3  D opcode: 0 AccessAck, 1 AccessAckData.
- d_source  input  SOURCE_BITS  D source.
- inflight  output  2^SOURCE_BITS  busy bitmap; bit i set means source i is outstanding.
- err_unsolicited  output  1  sticky: a D response fired for a source that was not in flight.

Behaviour:
- Reset, asynchronous on reset_n low: FIFO empty, rd/wr pointers 0, count 0, inflight 0, err_unsolicited 0. Resulting outputs: out_a_valid 0, in_a_ready 1, out_a_* fields 0. Reset mid-transfer discards queued entries and all in-flight state.
- Enqueue fire (in_a_fire) = in_a_valid & in_a_ready, where in_a_ready = (count != DEPTH). in_a_ready does not depend on same-cycle dequeue; a full FIFO refuses input even while out fires.
- Storage is registered; there is no flow-through. Minimum latency from in_a_fire to out_a_valid is 1 cycle.
- out_a_valid = (count != 0) & ~inflight[head.source]. out_a_* always reflect the head entry, or 0 when empty.
- Head-of-line blocking is intentional: a blocked head stalls younger entries, which preserves TL ordering.
- Dequeue fire (out_a_fire) = out_a_valid & out_a_ready: pops the head and sets inflight[head.source].
- D fire (d_fire) = d_valid & d_ready & (d_opcode == 0 | d_opcode == 1): clears inflight[d_source].
  - Other D opcodes are ignored.
  - If inflight[d_source] was already 0, err_unsolicited is set to 1 and holds until reset.
- Same-cycle d_fire and out_a_fire on the same source cannot occur, because the head is blocked while its source is in flight. d_fire clearing source X in cycle N unblocks a head with source X for cycle N+1, not cycle N.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- out_a_* hold stable while out_a_valid=1 and out_a_ready=0, per TL valid/ready rules.

Optional Feature:
- Macro: TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN.
- When defined:
  - Each in_a_fire beat is checked. The beat is legal only if opcode ∈ {0,1,4}, param == 0, and size <= log2(DATA_BITS/8).
  - An illegal beat is still accepted (in_a_ready unaffected) but is not written into the FIFO.
  - Added output port illegal_drop, 1 bit, pulses 1 for exactly the cycle after the illegal in_a_fire; reset value 0.
- When undefined: all beats are enqueued unchecked, and the illegal_drop port does not exist.

Test Plan:
- Reset then idle: reset_n low then high → out_a_valid=0, in_a_ready=1, inflight=4'b0000, err_unsolicited=0.
- Single Get: Get source 1, addr 0x1000, out_a_ready=1 → out_a_valid high one cycle later, out fires, inflight=4'b0010. AccessAckData source 1 fires → inflight=4'b0000.
- Source reuse block: two PutFull beats, both source 2, with no D response → second beat is held, out_a_valid=0. D AccessAck source 2 fires in cycle N → second beat out_a_valid=1 in cycle N+1.
- Full FIFO: three enqueues (sources 0,1,3) with out_a_ready=0 → first two accepted; in_a_ready=0 on the third until a pop. Data order is preserved.
- Unsolicited D: AccessAck source 3 fires with inflight=0 → err_unsolicited=1, and it stays 1 until reset_n low.
- Legal check, built with TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN: opcode 6 enqueued → illegal_drop=1 for one cycle, FIFO count unchanged, out_a_valid stays 0.

Source files
------------

// File: rtl/tl_ul_a_source_gate.sv
// TileLink-UL A-channel staging buffer with per-source in-flight gating.
// A requests are queued in a small registered FIFO. The head beat is
// released only when its source ID is not outstanding. A source becomes
// outstanding when its A beat fires downstream and is released when the
// matching D response (AccessAck/AccessAckData) fires.
// Optional build macro: TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN adds a legality
// filter on accepted beats and an illegal_drop output pulse.
module tl_ul_a_source_gate #(
  parameter int DEPTH       = 2,
  parameter int SOURCE_BITS = 2,
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BITS   = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  // upstream A
  input  logic                     in_a_valid,
  output logic                     in_a_ready,
  input  logic [2:0]               in_a_opcode,
  input  logic [2:0]               in_a_param,
  input  logic [2:0]               in_a_size,
  input  logic [SOURCE_BITS-1:0]   in_a_source,
  input  logic [ADDR_BITS-1:0]     in_a_address,
  input  logic [DATA_BITS/8-1:0]   in_a_mask,
  input  logic [DATA_BITS-1:0]     in_a_data,
  // downstream A
  output logic                     out_a_valid,
  input  logic                     out_a_ready,
  output logic [2:0]               out_a_opcode,
  output logic [2:0]               out_a_param,
  output logic [2:0]               out_a_size,
  output logic [SOURCE_BITS-1:0]   out_a_source,
  output logic [ADDR_BITS-1:0]     out_a_address,
  output logic [DATA_BITS/8-1:0]   out_a_mask,
  output logic [DATA_BITS-1:0]     out_a_data,
  // observed D
  input  logic                     d_valid,
  input  logic                     d_ready,
  input  logic [2:0]               d_opcode,
  input  logic [SOURCE_BITS-1:0]   d_source,
  // status
  output logic [(1<<SOURCE_BITS)-1:0] inflight,
`ifdef TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN
  output logic                     illegal_drop,
`endif
  output logic                     err_unsolicited
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int NSRC   = 1 << SOURCE_BITS;
  localparam int MASK_W = DATA_BITS / 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [2:0]             size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
    logic [MASK_W-1:0]      mask;
    logic [DATA_BITS-1:0]   data;
  } a_beat_t;

  a_beat_t                 mem [DEPTH];
  a_beat_t                 in_beat;
  a_beat_t                 head;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    empty;
  logic                    in_a_fire, out_a_fire, d_fire;
  logic                    enq;
  logic                    beat_legal;
  logic [NSRC-1:0]         inflight_nxt;

  assign in_beat = '{opcode:  in_a_opcode,  param: in_a_param, size: in_a_size,
                     source:  in_a_source,  address: in_a_address,
                     mask:    in_a_mask,    data: in_a_data};

  // Fullness only; same-cycle pops do not open a slot.
  assign empty      = (count == '0);
  assign in_a_ready = (count != FULL_CNT);
  assign in_a_fire  = in_a_valid & in_a_ready;

`ifdef TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN
  // Legal: PutFull/PutPartial/Get, zero param, size within one data beat.
  assign beat_legal = ((in_a_opcode == 3'd0) | (in_a_opcode == 3'd1) |
                       (in_a_opcode == 3'd4)) &
                      (in_a_param == 3'd0) &
                      (in_a_size <= 3'($clog2(MASK_W)));
`else
  assign beat_legal = 1'b1;
`endif

  // Illegal beats are handshaken upstream but never stored.
  assign enq = in_a_fire & beat_legal;

  // Head fields are zeroed when empty so stale storage never leaks out.
  assign head = empty ? '0 : mem[rd_ptr];

  assign out_a_opcode  = head.opcode;
  assign out_a_param   = head.param;
  assign out_a_size    = head.size;
  assign out_a_source  = head.source;
  assign out_a_address = head.address;
  assign out_a_mask    = head.mask;
  assign out_a_data    = head.data;

  // The head stalls while its source is outstanding (in-order, HOL blocking).
  assign out_a_valid = ~empty & ~inflight[head.source];
  assign out_a_fire  = out_a_valid & out_a_ready;

  assign d_fire = d_valid & d_ready & ((d_opcode == 3'd0) | (d_opcode == 3'd1));

  // FIFO storage write; data needs no reset since reads are masked by count.
  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= in_beat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)        wr_ptr <= wr_ptr + 1'b1;
      if (out_a_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, out_a_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // In-flight bitmap: D clears, A dequeue sets. They never hit the same
  // source in one cycle because a busy head source is blocked.
  always_comb begin
    inflight_nxt = inflight;
    if (d_fire)     inflight_nxt[d_source]    = 1'b0;
    if (out_a_fire) inflight_nxt[head.source] = 1'b1;
  end

  // In-flight register and sticky unsolicited-response flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight        <= '0;
      err_unsolicited <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (d_fire && !inflight[d_source]) err_unsolicited <= 1'b1;
    end
  end

`ifdef TL_UL_A_SOURCE_GATE_LEGAL_CHECK_EN
  // One-cycle pulse following a dropped beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) illegal_drop <= 1'b0;
    else          illegal_drop <= in_a_fire & ~beat_legal;
  end
`endif

endmodule
